scan_word: RTL and testbench

//  Receive-side counterpart of the debug unit's byte/word print path.

---
 rtl/scan_word.sv | 174 +++++++++++++++++
 tb/tb_scan_word.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_word.sv
// scan_word: receive-side byte/word collector for the debug controller.
// Assembles one byte or one little-endian 32-bit word from UART receiver
// strobes and hands it over with a four-phase req_rx/ack_rx exchange.
// An inter-byte timeout ends a word that stalls after its first byte.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request pending, bytes from the receiver are dropped
// RECV  | accepting bytes into the staging register, timeout armed after byte 0
// DONE  | ack_rx (and err_rx) held until the controller drops req_rx

module scan_word #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clk_tx,
  input  logic        rst,
  input  logic        req_rx,
  input  logic        type_rx,
  input  logic        vld_rx,
  input  logic [7:0]  d_rx,
  output logic        rdy_rx,
  output logic [31:0] din_rx,
  output logic        ack_rx,
  output logic        err_rx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bit             TO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

  state_t             state;
  state_t             state_nx;
  logic               word_q;
  logic [2:0]         count;
  logic [CNT_W-1:0]   timer;
  logic [31:0]        stage;
  logic [31:0]        stage_merge;

  logic               accept;
  logic               last_byte;
  logic               timeout_hit;

  logic               rdy_nx;
  logic               ack_nx;
  logic               err_nx;
  logic [31:0]        din_nx;

  // rdy_rx is registered and high exactly while in RECV, so it qualifies the strobe
  assign accept      = vld_rx && rdy_rx;
  assign last_byte   = accept && (word_q ? (count == 3'd3) : (count == 3'd0));
  // timer only advances once a byte has been taken, so count!=0 keeps the
  // wait for the first byte unbounded
  assign timeout_hit = TO_EN && (count != 3'd0) && (timer == TO_VAL);

  // Merge the incoming byte into its little-endian lane of the staging value
  always_comb begin
    stage_merge = stage;
    case (count[1:0])
      2'd0:    stage_merge[7:0]   = d_rx;
      2'd1:    stage_merge[15:8]  = d_rx;
      2'd2:    stage_merge[23:16] = d_rx;
      default: stage_merge[31:24] = d_rx;
    endcase
  end

  // State register
  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; an accepted byte always beats a coincident timeout,
  // and a dropped request beats everything while receiving
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_rx) begin
          state_nx = RECV;
        end
      end
      RECV: begin
        if (!req_rx) begin
          state_nx = IDLE;
        end else if (last_byte) begin
          state_nx = DONE;
        end else if (timeout_hit && !accept) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!req_rx) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken
  always_comb begin
    rdy_nx = (state_nx == RECV);
    ack_nx = (state_nx == DONE);
    err_nx = 1'b0;
    din_nx = din_rx;
    if (state == RECV && state_nx == DONE) begin
      if (last_byte) begin
        din_nx = word_q ? stage_merge : {24'd0, stage_merge[7:0]};
      end else begin
        err_nx = 1'b1;
      end
    end else if (state == DONE && state_nx == DONE) begin
      err_nx = err_rx;
    end
  end

  // Output registers
  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      rdy_rx <= 1'b0;
      ack_rx <= 1'b0;
      err_rx <= 1'b0;
      din_rx <= 32'd0;
    end else begin
      rdy_rx <= rdy_nx;
      ack_rx <= ack_nx;
      err_rx <= err_nx;
      din_rx <= din_nx;
    end
  end

  // Request type, byte count, inter-byte timer and staging value
  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      word_q <= 1'b0;
      count  <= 3'd0;
      timer  <= '0;
      stage  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_rx) begin
            word_q <= type_rx;
            count  <= 3'd0;
            timer  <= '0;
            stage  <= 32'd0;
          end
        end
        RECV: begin
          if (accept) begin
            stage <= stage_merge;
            count <= count + 3'd1;
            timer <= '0;
          end else if (count != 3'd0 && timer != '1) begin
            // saturate so a disabled timeout never wraps into a false match
            timer <= timer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_word.sv
// Bench for scan_word: table of byte/word requests plus hand sequences for
// timeout, timeout/final-byte tie, abort, dropped bytes and reset in DONE.
module tb_scan_word;

  logic        clk_tx = 1'b0;
  logic        rst;
  logic        req_rx;
  logic        type_rx;
  logic        vld_rx;
  logic [7:0]  d_rx;
  logic        rdy_rx;
  logic [31:0] din_rx;
  logic        ack_rx;
  logic        err_rx;

  scan_word #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk_tx (clk_tx),
    .rst    (rst),
    .req_rx (req_rx),
    .type_rx(type_rx),
    .vld_rx (vld_rx),
    .d_rx   (d_rx),
    .rdy_rx (rdy_rx),
    .din_rx (din_rx),
    .ack_rx (ack_rx),
    .err_rx (err_rx)
  );

  always #5 clk_tx = ~clk_tx;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] din;
    logic        err;
  } exp_t;

  typedef struct {
    logic        word;
    logic [31:0] data;
    int          gap;
    logic [31:0] exp_din;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[6];
  logic [31:0] model_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_tx);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    vld_rx = 1'b1;
    d_rx   = b;
    tick();
    vld_rx = 1'b0;
    d_rx   = 8'h00;
  endtask

  task automatic sb_pop(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (ack_rx !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (ack_rx !== 1'b1) begin
      check({name, "_ack_wait"}, {31'd0, ack_rx}, 32'd1);
    end else if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: ack seen with empty scoreboard, din %h", name, din_rx);
    end else begin
      e = exp_q.pop_front();
      check({name, "_din"}, din_rx, e.din);
      check({name, "_err"}, {31'd0, err_rx}, {31'd0, e.err});
    end
  endtask

  task automatic do_txn(input string name, input logic word, input logic [31:0] data,
                        input int gap, input logic [31:0] exp_din, input bit hold);
    int nb;
    nb = word ? 4 : 1;
    req_rx  = 1'b1;
    type_rx = word;
    tick();
    type_rx = 1'b0;
    check({name, "_rdy"}, {31'd0, rdy_rx}, 32'd1);
    for (int k = 0; k < nb; k++) begin
      repeat ((gap * k) % 6) tick();
      if (k == nb - 1) exp_q.push_back('{din: exp_din, err: 1'b0});
      send_byte(data[8*k +: 8]);
    end
    check({name, "_ack_lat"}, {31'd0, ack_rx}, 32'd1);
    sb_pop(name);
    check({name, "_rdy_done"}, {31'd0, rdy_rx}, 32'd0);
    model_din = exp_din;
    if (!hold) begin
      req_rx = 1'b0;
      tick();
      check({name, "_ack_drop"}, {31'd0, ack_rx}, 32'd0);
      check({name, "_err_drop"}, {31'd0, err_rx}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h000000A5, 0, 32'h000000A5};
    vecs[1] = '{1'b1, 32'h12345678, 0, 32'h12345678};
    vecs[2] = '{1'b1, 32'h12345678, 1, 32'h12345678};
    vecs[3] = '{1'b1, 32'hDEADBEEF, 5, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 32'h000000FF, 2, 32'h000000FF};
    vecs[5] = '{1'b1, 32'h89ABCDEF, 2, 32'h89ABCDEF};

    rst = 1'b1; req_rx = 1'b0; type_rx = 1'b0; vld_rx = 1'b0; d_rx = 8'h00;
    model_din = 32'd0;
    repeat (2) tick();
    check("rst_rdy", {31'd0, rdy_rx}, 32'd0);
    check("rst_ack", {31'd0, ack_rx}, 32'd0);
    check("rst_err", {31'd0, err_rx}, 32'd0);
    check("rst_din", din_rx, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].word, vecs[i].data, vecs[i].gap,
             vecs[i].exp_din, 1'b0);
      tick();
    end

    // timeout: two bytes, then silence; ack with err after the 17th edge
    req_rx = 1'b1; type_rx = 1'b1;
    tick();
    type_rx = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (16) tick();
    check("to_early", {31'd0, ack_rx}, 32'd0);
    exp_q.push_back('{din: model_din, err: 1'b1});
    tick();
    check("to_ack_lat", {31'd0, ack_rx}, 32'd1);
    sb_pop("to");
    check("to_rdy", {31'd0, rdy_rx}, 32'd0);
    req_rx = 1'b0;
    tick();
    check("to_ack_drop", {31'd0, ack_rx}, 32'd0);
    check("to_err_drop", {31'd0, err_rx}, 32'd0);
    tick();

    // final byte arrives in the same cycle the timeout would fire
    req_rx = 1'b1; type_rx = 1'b1;
    tick();
    type_rx = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (16) tick();
    check("tie_early", {31'd0, ack_rx}, 32'd0);
    exp_q.push_back('{din: 32'h44332211, err: 1'b0});
    send_byte(8'h44);
    check("tie_ack_lat", {31'd0, ack_rx}, 32'd1);
    sb_pop("tie");
    model_din = 32'h44332211;
    req_rx = 1'b0;
    tick();
    tick();

    // abort after three bytes
    req_rx = 1'b1; type_rx = 1'b1;
    tick();
    type_rx = 1'b0;
    send_byte(8'hE1);
    send_byte(8'hE2);
    send_byte(8'hE3);
    req_rx = 1'b0;
    tick();
    check("abort_rdy", {31'd0, rdy_rx}, 32'd0);
    repeat (3) tick();
    check("abort_ack", {31'd0, ack_rx}, 32'd0);
    check("abort_din", din_rx, model_din);
    do_txn("abort_next", 1'b1, 32'h04030201, 1, 32'h04030201, 1'b0);
    tick();

    // dropped bytes in IDLE and DONE
    send_byte(8'h99);
    send_byte(8'h98);
    do_txn("drop_first", 1'b0, 32'h0000005A, 0, 32'h0000005A, 1'b1);
    send_byte(8'h77);
    check("drop_done_din", din_rx, 32'h0000005A);
    check("drop_done_ack", {31'd0, ack_rx}, 32'd1);
    req_rx = 1'b0;
    tick();
    send_byte(8'h66);
    do_txn("drop_next", 1'b0, 32'h0000003C, 3, 32'h0000003C, 1'b0);
    tick();

    // reset while holding ack in DONE
    do_txn("rst_pre", 1'b0, 32'h000000C3, 0, 32'h000000C3, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_ack", {31'd0, ack_rx}, 32'd0);
    check("rst_mid_din", din_rx, 32'd0);
    check("rst_mid_rdy", {31'd0, rdy_rx}, 32'd0);
    req_rx = 1'b0;
    model_din = 32'd0;
    tick();
    rst = 1'b0;
    tick();
    do_txn("rst_post", 1'b1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
